// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and slice-count helpers.
package adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Number of clock cycles (slices) needed to cover the full operand width.
  function automatic int unsigned calc_k(input int unsigned width, input int unsigned bpc);
    return width / bpc;
  endfunction

  // Slice counter width; a single-slice adder still needs a 1-bit counter.
  function automatic int unsigned calc_cnt_w(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational BPC-bit ripple of 1-bit full adders; exposes the carry into its top bit
// so the caller can derive signed overflow.
module fa_slice #(
  parameter int unsigned BPC = 1
) (
  input  logic [BPC-1:0] i_a,
  input  logic [BPC-1:0] i_b,
  input  logic           i_ci,
  output logic [BPC-1:0] o_s,
  output logic           o_co,
  output logic           o_c_msb_in
);

  // Ripple the carry through the slice, noting the carry entering the top bit.
  always_comb begin
    logic w_c;
    w_c        = i_ci;
    o_s        = '0;
    o_c_msb_in = 1'b0;
    for (int i = 0; i < int'(BPC); i++) begin
      if (i == int'(BPC) - 1) begin
        o_c_msb_in = w_c;
      end
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle WIDTH-bit adder/subtractor: one BPC-bit slice per clock, LSB first,
// with a start/busy/done handshake.
module serial_adder_n
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_ovf
);

  localparam int unsigned K  = calc_k(WIDTH, BPC);
  localparam int unsigned CW = calc_cnt_w(K);

  if (WIDTH < 2 || BPC == 0 || (WIDTH % BPC) != 0) begin : g_bad_params
    $error("serial_adder_n: BPC must divide WIDTH and WIDTH must be >= 2");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [BPC-1:0]   w_sum;
  logic             w_co;
  logic             w_c_msb_in;
  logic [WIDTH-1:0] w_s_next;

  // Operands shift right each cycle so the active slice is always in the low BPC bits.
  fa_slice #(
    .BPC (BPC)
  ) u_fa_slice (
    .i_a        (r_a[BPC-1:0]),
    .i_b        (r_b[BPC-1:0]),
    .i_ci       (r_carry),
    .o_s        (w_sum),
    .o_co       (w_co),
    .o_c_msb_in (w_c_msb_in)
  );

  assign w_accept = i_start && (r_state == StIdle || r_state == StDone);
  assign w_last   = (r_cnt == CW'(K - 1));

  // Merge the freshly computed slice into its position in the result.
  always_comb begin
    w_s_next = r_s;
    w_s_next[r_cnt * BPC +: BPC] = w_sum;
  end

  // FSM, operand shifters, carry flop, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            r_a     <= i_a;
            // Subtraction is A + ~B + 1: invert B and force the carry-in.
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub | i_ci;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_a     <= r_a >> BPC;
          r_b     <= r_b >> BPC;
          r_carry <= w_co;
          r_s     <= w_s_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_co    <= w_co;
            r_ovf   <= w_co ^ w_c_msb_in;
            r_state <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = (r_state == StRun);
  assign o_done = (r_state == StDone);
  assign o_s    = r_s;
  assign o_co   = r_co;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: an 8-bit/1-bit-per-clock instance and a
// 16-bit/4-bits-per-clock instance, checked against an integer-arithmetic model.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        s8_start = 1'b0;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic        s8_ci = 1'b0, s8_sub = 1'b0;
  logic        o8_busy, o8_done, o8_co, o8_ovf;
  logic [7:0]  o8_s;

  logic        s16_start = 1'b0;
  logic [15:0] s16_a = '0, s16_b = '0;
  logic        s16_ci = 1'b0, s16_sub = 1'b0;
  logic        o16_busy, o16_done, o16_co, o16_ovf;
  logic [15:0] o16_s;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] last_s;
  logic        last_co, last_ovf;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .BPC(1)) u_dut8 (
    .clk(clk), .rst(rst), .i_start(s8_start), .i_a(s8_a), .i_b(s8_b), .i_ci(s8_ci),
    .i_sub(s8_sub), .o_busy(o8_busy), .o_done(o8_done), .o_s(o8_s), .o_co(o8_co),
    .o_ovf(o8_ovf)
  );

  serial_adder_n #(.WIDTH(16), .BPC(4)) u_dut16 (
    .clk(clk), .rst(rst), .i_start(s16_start), .i_a(s16_a), .i_b(s16_b), .i_ci(s16_ci),
    .i_sub(s16_sub), .o_busy(o16_busy), .o_done(o16_done), .o_s(o16_s), .o_co(o16_co),
    .o_ovf(o16_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic obs_busy(input bit wide);
    return wide ? o16_busy : o8_busy;
  endfunction

  function automatic logic obs_done(input bit wide);
    return wide ? o16_done : o8_done;
  endfunction

  function automatic logic [15:0] obs_s(input bit wide);
    return wide ? o16_s : {8'h00, o8_s};
  endfunction

  // Reference: plain unsigned sum for result/carry, signed range test for overflow.
  function automatic logic [17:0] model(input bit wide, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sub);
    longint m, ua, ub, c, sum, sa, sb, sr;
    logic   co, ovf;
    m   = longint'(1) << (wide ? 16 : 8);
    ua  = longint'(a) & (m - 1);
    ub  = longint'(sub ? ~b : b) & (m - 1);
    c   = (sub || ci) ? 1 : 0;
    sum = ua + ub + c;
    co  = (sum >= m);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sb  = (ub >= m / 2) ? ub - m : ub;
    sr  = sa + sb + c;
    ovf = (sr > m / 2 - 1) || (sr < -(m / 2));
    return {ovf, co, 16'(sum % m)};
  endfunction

  task automatic drive(input bit wide, input logic start, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input logic sub);
    if (wide) begin
      s16_start = start; s16_a = a; s16_b = b; s16_ci = ci; s16_sub = sub;
    end else begin
      s8_start = start; s8_a = a[7:0]; s8_b = b[7:0]; s8_ci = ci; s8_sub = sub;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with operands scrambled.
  task automatic start_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sub);
    drive(wide, 1'b1, a, b, ci, sub);
    @(posedge clk);
    @(negedge clk);
    drive(wide, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Steps negedge by negedge until done, counting cycles since the accepting edge.
  task automatic wait_done(input bit wide, input int cyc0, output int cyc, output int busy_n);
    bit ok;
    ok = 1'b0;
    cyc = cyc0;
    busy_n = 0;
    for (int i = 0; i < 64; i++) begin
      if (obs_done(wide)) begin
        ok = 1'b1;
        break;
      end
      if (obs_busy(wide)) busy_n++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
    last_s   = obs_s(wide);
    last_co  = wide ? o16_co : o8_co;
    last_ovf = wide ? o16_ovf : o8_ovf;
  endtask

  task automatic check_model(input bit wide, input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic sub, input string tag);
    logic [17:0] e;
    e = model(wide, a, b, ci, sub);
    chk({tag, "_s"}, 32'(last_s), 32'(e[15:0]));
    chk({tag, "_co"}, 32'(last_co), 32'(e[16]));
    chk({tag, "_ovf"}, 32'(last_ovf), 32'(e[17]));
  endtask

  task automatic do_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sub, input string tag);
    int cyc, busy_n, k;
    k = wide ? 4 : 8;
    start_op(wide, a, b, ci, sub);
    wait_done(wide, 0, cyc, busy_n);
    chk({tag, "_latency"}, 32'(cyc), 32'(k));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(k));
    check_model(wide, a, b, ci, sub, tag);
  endtask

  initial begin
    int cyc, busy_n, seen;
    logic [15:0] ra, rb;
    logic rci, rsub;

    // Reset state while reset is held.
    #1;
    chk("rst8_busy", 32'(o8_busy), 0);
    chk("rst8_done", 32'(o8_done), 0);
    chk("rst8_s", 32'(o8_s), 0);
    chk("rst16_co", 32'(o16_co), 0);
    chk("rst16_ovf", 32'(o16_ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic add, plus single-cycle done pulse.
    do_op(1'b0, 16'h3C, 16'h5A, 1'b0, 1'b0, "add");
    chk("add_s_const", 32'(last_s), 32'h96);
    chk("add_co_const", 32'(last_co), 0);
    chk("add_ovf_const", 32'(last_ovf), 1);
    @(posedge clk);
    @(negedge clk);
    chk("add_done_one_cycle", 32'(o8_done), 0);
    chk("add_s_held", 32'(o8_s), 32'h96);

    // 2: subtraction with borrow and signed overflow.
    do_op(1'b0, 16'h00, 16'h01, 1'b0, 1'b1, "sub0");
    chk("sub0_s_const", 32'(last_s), 32'hFF);
    chk("sub0_co_const", 32'(last_co), 0);
    chk("sub0_ovf_const", 32'(last_ovf), 0);
    do_op(1'b0, 16'h80, 16'h01, 1'b0, 1'b1, "sub1");
    chk("sub1_s_const", 32'(last_s), 32'h7F);
    chk("sub1_co_const", 32'(last_co), 1);
    chk("sub1_ovf_const", 32'(last_ovf), 1);

    // 3: carry-in full wrap, then every {ci,a0,b0} combination.
    do_op(1'b0, 16'hFF, 16'h00, 1'b1, 1'b0, "wrap");
    chk("wrap_s_const", 32'(last_s), 0);
    chk("wrap_co_const", 32'(last_co), 1);
    chk("wrap_ovf_const", 32'(last_ovf), 0);
    for (int v = 0; v < 8; v++) begin
      ra = {8'h00, 7'($urandom), 1'(v >> 1)};
      rb = {8'h00, 7'($urandom), 1'(v)};
      do_op(1'b0, ra, rb, 1'(v >> 2), 1'b0, "combo");
    end

    // 4a: start during RUN is ignored.
    start_op(1'b0, 16'h21, 16'h13, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 16'hAA, 16'hAA, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
    wait_done(1'b0, 3, cyc, busy_n);
    chk("ign_latency", 32'(cyc), 8);
    chk("ign_s", 32'(last_s), 32'h34);
    @(posedge clk);
    @(negedge clk);
    chk("ign_no_second_op", 32'(o8_busy), 0);

    // 4b: back-to-back start during DONE.
    start_op(1'b0, 16'h7F, 16'h01, 1'b0, 1'b0);
    wait_done(1'b0, 0, cyc, busy_n);
    check_model(1'b0, 16'h7F, 16'h01, 1'b0, 1'b0, "b2b_first");
    start_op(1'b0, 16'h10, 16'h20, 1'b0, 1'b1);
    chk("b2b_no_bubble", 32'(o8_busy), 1);
    wait_done(1'b0, 0, cyc, busy_n);
    chk("b2b_done_spacing", 32'(cyc), 8);
    check_model(1'b0, 16'h10, 16'h20, 1'b0, 1'b1, "b2b_second");

    // 5: reset mid-RUN aborts, then a normal op completes.
    start_op(1'b0, 16'h55, 16'h33, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(o8_busy), 0);
    chk("abort_done", 32'(o8_done), 0);
    chk("abort_s", 32'(o8_s), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o8_done || o8_busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);
    do_op(1'b0, 16'h55, 16'h33, 1'b0, 1'b0, "post_rst");

    // 6: 16-bit, 4 bits per clock.
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "w16");
    chk("w16_s_const", 32'(last_s), 0);
    chk("w16_co_const", 32'(last_co), 1);

    // Random runs against the model.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom); rsub = 1'($urandom);
      do_op(1'b1, ra, rb, rci, rsub, "rnd16");
    end
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom); rsub = 1'($urandom);
      do_op(1'b0, {8'h00, ra[7:0]}, {8'h00, rb[7:0]}, rci, rsub, "rnd8");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
